sdram_arbiter: RTL and testbench
================================

// Module: sdram_arbiter
// PURPOSE
//  Central SDRAM command arbiter: sequences init -> idle-arbitrate, and grants the bus to the
//  auto-refresh, write and read engines. Refresh has strict priority; write/read alternate
//  round-robin on ties. Muxes cmd/addr/bank/DQ-drive from the granted engine onto the pins.
//  Adds the read channel, a fair write/read policy, a grant watchdog and parametrised widths.
// PARAMETERS
//  ADDR_W       13       SDRAM address width
//  BA_W         2        bank address width
//  DATA_W       16       DQ width
//  TIMEOUT_CYC  64       max cycles a grant may last before forced release (>=2)
//  CMD_NOP      4'b0111  {CS_N,RAS_N,CAS_N,WE_N} NOP encoding
// PORTS
//  clk          in   1       system clock
//  rst          in   1       asynchronous reset, active-high
//  init_done    in   1       init engine finished (level or pulse)
//  init_cmd     in   4       init engine command
//  init_addr    in   ADDR_W  init engine address (mode register value)
//  aref_req     in   1       refresh request (level, held until served)
//  aref_cmd     in   4       refresh engine command
//  aref_end     in   1       refresh complete pulse
//  aref_en      out  1       refresh grant (level)
//  wr_req       in   1       write request (level)
//  wr_cmd       in   4       write engine command
//  wr_addr      in   ADDR_W  write engine address
//  wr_ba        in   BA_W    write engine bank
//  wr_data      in   DATA_W  write data
//  wr_end       in   1       write burst complete pulse
//  wr_en        out  1       write grant (level)
//  rd_req / rd_cmd / rd_addr / rd_ba / rd_end / rd_en   read channel, same meaning as write
//  sdram_cmd    out  4       {CS_N,RAS_N,CAS_N,WE_N} to pins
//  sdram_addr   out  ADDR_W  address to pins
//  sdram_ba     out  BA_W    bank to pins
//  sdram_dq_out out  DATA_W  DQ drive value
//  sdram_dq_oe  out  1       DQ output enable (top-level tristate)
//  timeout_err  out  1       one-cycle pulse on watchdog release
//  err_sticky   out  1       set by any timeout, cleared only by rst
// BEHAVIOUR
//  - States IDLE, ARBIT, AREF, WRITE, READ (one-hot, registered). Reset -> IDLE.
//  - Reset values: aref_en/wr_en/rd_en=0, dq_oe=0, timeout_err=0, err_sticky=0, last_rd=1,
//    watchdog=0; sdram_cmd=CMD_NOP, sdram_addr=0, sdram_ba=0 while rst high.
//  - IDLE: pins follow init_cmd/init_addr, ba=0; init_done=1 -> ARBIT next cycle. init_done ignored elsewhere.
//  - ARBIT: pins NOP, addr/ba=0. Priority sampled in ARBIT at cycle t, new state at t+1:
//    aref_req -> AREF; else wr_req&rd_req -> WRITE if last_rd=1 else READ; else single req wins.
//  - Grants: aref_en/wr_en/rd_en = (state==AREF/WRITE/READ); pins mux from that engine
//    combinationally on current state (AREF: addr/ba=0). Request drop during grant ignored.
//  - *_end of granted engine at t -> ARBIT at t+1; *_end from non-granted engine ignored.
//    At least one ARBIT cycle between any two grants. last_rd updated on READ/WRITE exit.
//  - dq_oe = (state==WRITE); dq_out = wr_data in WRITE, else 0.
//  - Watchdog: cleared on grant entry, +1 per granted cycle; reaching TIMEOUT_CYC-1 without
//    *_end -> ARBIT next cycle, timeout_err pulses 1 cycle, err_sticky set; last_rd updated
//    as on normal exit. *_end in the same cycle as expiry = normal end, no error.
//  - rst assertion mid-grant: immediate async return to IDLE, all grants drop, pins NOP;
//    init must complete again before any grant.
// TESTING
//  1. rst 1->0, init_done at cycle 10 -> pins=init_cmd to cycle 10, ARBIT at 11, NOP, no grants.
//  2. ARBIT, aref_req=wr_req=rd_req=1 same cycle -> aref_en at t+1; after aref_end, WRITE
//     (last_rd=1), then READ, then WRITE: strict alternation, one ARBIT cycle between each.
//  3. WRITE grant, wr_data=16'hA5A5 -> dq_oe=1, dq_out=A5A5, pins=wr_cmd/wr_addr/wr_ba;
//     wr_end -> dq_oe=0 next cycle.
//  4. READ grant, rd_end never asserted, TIMEOUT_CYC=8 -> rd_en drops after 8 cycles,
//     timeout_err one pulse, err_sticky=1 until rst; rd_end on cycle 8 instead -> no error.
//  5. rst asserted 3 cycles into WRITE -> wr_en=0, dq_oe=0, sdram_cmd=4'b0111 same cycle;
//     no grant until new init_done.

Source files
------------

// File: rtl/sdram_arbiter.sv
// SDRAM command arbiter: init hand-off, then strict-priority refresh and
// round-robin write/read grants with a per-grant watchdog.
module sdram_arbiter #(
    parameter int          ADDR_W      = 13,
    parameter int          BA_W        = 2,
    parameter int          DATA_W      = 16,
    parameter int          TIMEOUT_CYC = 64,
    parameter logic [3:0]  CMD_NOP     = 4'b0111
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              init_done,
    input  logic [3:0]        init_cmd,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic              aref_req,
    input  logic [3:0]        aref_cmd,
    input  logic              aref_end,
    output logic              aref_en,
    input  logic              wr_req,
    input  logic [3:0]        wr_cmd,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [BA_W-1:0]   wr_ba,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_end,
    output logic              wr_en,
    input  logic              rd_req,
    input  logic [3:0]        rd_cmd,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [BA_W-1:0]   rd_ba,
    input  logic              rd_end,
    output logic              rd_en,
    output logic [3:0]        sdram_cmd,
    output logic [ADDR_W-1:0] sdram_addr,
    output logic [BA_W-1:0]   sdram_ba,
    output logic [DATA_W-1:0] sdram_dq_out,
    output logic              sdram_dq_oe,
    output logic              timeout_err,
    output logic              err_sticky
);

    localparam int WD_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic [4:0] {
        IDLE  = 5'b00001,
        ARBIT = 5'b00010,
        AREF  = 5'b00100,
        WRITE = 5'b01000,
        READ  = 5'b10000
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [WD_W-1:0] wd;
    logic            last_rd;
    logic            granted;
    logic            grant_end;
    logic            expire;

    always_comb begin
        granted   = (state == AREF) || (state == WRITE) || (state == READ);
        grant_end = 1'b0;
        case (state)
            AREF:    grant_end = aref_end;
            WRITE:   grant_end = wr_end;
            READ:    grant_end = rd_end;
            default: grant_end = 1'b0;
        endcase
        // An end pulse on the final cycle wins over the watchdog
        expire = granted && !grant_end && (wd == WD_W'(TIMEOUT_CYC - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (init_done)
                    state_nxt = ARBIT;
            end
            ARBIT: begin
                if (aref_req)
                    state_nxt = AREF;
                else if (wr_req && rd_req)
                    state_nxt = last_rd ? WRITE : READ;
                else if (wr_req)
                    state_nxt = WRITE;
                else if (rd_req)
                    state_nxt = READ;
            end
            AREF, WRITE, READ: begin
                if (grant_end || expire)
                    state_nxt = ARBIT;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        aref_en      = (state == AREF);
        wr_en        = (state == WRITE);
        rd_en        = (state == READ);
        sdram_cmd    = CMD_NOP;
        sdram_addr   = '0;
        sdram_ba     = '0;
        sdram_dq_out = '0;
        sdram_dq_oe  = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    sdram_cmd  = init_cmd;
                    sdram_addr = init_addr;
                end
                AREF: sdram_cmd = aref_cmd;
                WRITE: begin
                    sdram_cmd    = wr_cmd;
                    sdram_addr   = wr_addr;
                    sdram_ba     = wr_ba;
                    sdram_dq_out = wr_data;
                    sdram_dq_oe  = 1'b1;
                end
                READ: begin
                    sdram_cmd  = rd_cmd;
                    sdram_addr = rd_addr;
                    sdram_ba   = rd_ba;
                end
                default: sdram_cmd = CMD_NOP;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd          <= '0;
            last_rd     <= 1'b1;
            timeout_err <= 1'b0;
            err_sticky  <= 1'b0;
        end else begin
            wd          <= granted ? wd + 1'b1 : '0;
            timeout_err <= expire;
            err_sticky  <= err_sticky | expire;
            if ((state == WRITE) && (grant_end || expire))
                last_rd <= 1'b0;
            else if ((state == READ) && (grant_end || expire))
                last_rd <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Scoreboard bench for sdram_arbiter: expected grant order is queued by the
// stimulus and checked by a negedge monitor; pins are checked directly.
module tb_sdram_arbiter;

    localparam int ADDR_W = 13;
    localparam int BA_W   = 2;
    localparam int DATA_W = 16;
    localparam logic [2:0] G_AREF = 3'b100;
    localparam logic [2:0] G_WR   = 3'b010;
    localparam logic [2:0] G_RD   = 3'b001;

    logic              clk = 1'b0;
    logic              rst;
    logic              init_done;
    logic [3:0]        init_cmd;
    logic [ADDR_W-1:0] init_addr;
    logic              aref_req;
    logic [3:0]        aref_cmd;
    logic              aref_end;
    logic              aref_en;
    logic              wr_req;
    logic [3:0]        wr_cmd;
    logic [ADDR_W-1:0] wr_addr;
    logic [BA_W-1:0]   wr_ba;
    logic [DATA_W-1:0] wr_data;
    logic              wr_end;
    logic              wr_en;
    logic              rd_req;
    logic [3:0]        rd_cmd;
    logic [ADDR_W-1:0] rd_addr;
    logic [BA_W-1:0]   rd_ba;
    logic              rd_end;
    logic              rd_en;
    logic [3:0]        sdram_cmd;
    logic [ADDR_W-1:0] sdram_addr;
    logic [BA_W-1:0]   sdram_ba;
    logic [DATA_W-1:0] sdram_dq_out;
    logic              sdram_dq_oe;
    logic              timeout_err;
    logic              err_sticky;

    int n_tests = 0;
    int n_fail  = 0;
    logic [2:0] exp_q[$];
    logic [2:0] prev_g = 3'b000;

    sdram_arbiter #(
        .ADDR_W(ADDR_W), .BA_W(BA_W), .DATA_W(DATA_W),
        .TIMEOUT_CYC(8), .CMD_NOP(4'b0111)
    ) dut (
        .clk(clk), .rst(rst),
        .init_done(init_done), .init_cmd(init_cmd), .init_addr(init_addr),
        .aref_req(aref_req), .aref_cmd(aref_cmd), .aref_end(aref_end),
        .aref_en(aref_en),
        .wr_req(wr_req), .wr_cmd(wr_cmd), .wr_addr(wr_addr), .wr_ba(wr_ba),
        .wr_data(wr_data), .wr_end(wr_end), .wr_en(wr_en),
        .rd_req(rd_req), .rd_cmd(rd_cmd), .rd_addr(rd_addr), .rd_ba(rd_ba),
        .rd_end(rd_end), .rd_en(rd_en),
        .sdram_cmd(sdram_cmd), .sdram_addr(sdram_addr), .sdram_ba(sdram_ba),
        .sdram_dq_out(sdram_dq_out), .sdram_dq_oe(sdram_dq_oe),
        .timeout_err(timeout_err), .err_sticky(err_sticky)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Grant monitor: each new grant must match the head of the queue
    always @(negedge clk) begin
        logic [2:0] g;
        g = {aref_en, wr_en, rd_en};
        chk("grant_onehot", {31'd0, $onehot0(g)}, 32'd1);
        if (g != 3'b000 && prev_g == 3'b000) begin
            if (exp_q.size() == 0)
                chk("unexpected_grant", {29'd0, g}, 32'd0);
            else
                chk("grant_order", {29'd0, g}, {29'd0, exp_q.pop_front()});
        end
        if (g != 3'b000 && prev_g != 3'b000 && g != prev_g)
            chk("arbit_gap", {29'd0, g}, {29'd0, prev_g});
        prev_g = g;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        int cnt;
        int te;
        rst = 1'b1; init_done = 1'b0;
        init_cmd = 4'b0010; init_addr = 13'h0A5B;
        aref_req = 1'b0; aref_cmd = 4'b0001; aref_end = 1'b0;
        wr_req = 1'b0; wr_cmd = 4'b0100; wr_addr = 13'h1234;
        wr_ba = 2'd2; wr_data = 16'hA5A5; wr_end = 1'b0;
        rd_req = 1'b0; rd_cmd = 4'b0101; rd_addr = 13'h0777;
        rd_ba = 2'd1; rd_end = 1'b0;
        #1;
        chk("rst_cmd", {28'd0, sdram_cmd}, 32'h7);
        chk("rst_addr", {19'd0, sdram_addr}, 32'h0);
        chk("rst_grants", {29'd0, aref_en, wr_en, rd_en}, 32'h0);
        chk("rst_err", {30'd0, timeout_err, err_sticky}, 32'h0);
        tick(); tick();

        // Init hand-off: pins follow the init engine until init_done
        rst = 1'b0;
        #1;
        chk("idle_cmd", {28'd0, sdram_cmd}, 32'h2);
        chk("idle_addr", {19'd0, sdram_addr}, 32'h0A5B);
        repeat (10) tick();
        init_done = 1'b1;
        #1;
        chk("idle_cmd_c10", {28'd0, sdram_cmd}, 32'h2);
        tick();
        init_done = 1'b0;
        chk("arbit_cmd", {28'd0, sdram_cmd}, 32'h7);
        chk("arbit_addr", {19'd0, sdram_addr}, 32'h0);
        chk("arbit_nogrant", {29'd0, aref_en, wr_en, rd_en}, 32'h0);

        // All three requests at once: refresh, then write/read alternate
        exp_q.push_back(G_AREF);
        exp_q.push_back(G_WR);
        exp_q.push_back(G_RD);
        exp_q.push_back(G_WR);
        aref_req = 1'b1; wr_req = 1'b1; rd_req = 1'b1;
        tick();
        chk("aref_en", {31'd0, aref_en}, 32'h1);
        chk("aref_cmd", {28'd0, sdram_cmd}, 32'h1);
        chk("aref_addr", {19'd0, sdram_addr}, 32'h0);
        tick();
        aref_end = 1'b1; aref_req = 1'b0;
        tick();
        aref_end = 1'b0;
        chk("gap1_cmd", {28'd0, sdram_cmd}, 32'h7);
        tick();
        chk("wr_en", {31'd0, wr_en}, 32'h1);
        chk("wr_cmd", {28'd0, sdram_cmd}, 32'h4);
        chk("wr_addr", {19'd0, sdram_addr}, 32'h1234);
        chk("wr_ba", {30'd0, sdram_ba}, 32'h2);
        chk("wr_oe", {31'd0, sdram_dq_oe}, 32'h1);
        chk("wr_dq", {16'd0, sdram_dq_out}, 32'hA5A5);
        rd_end = 1'b1;
        tick();
        rd_end = 1'b0;
        chk("wr_ignores_rd_end", {31'd0, wr_en}, 32'h1);
        wr_end = 1'b1;
        tick();
        wr_end = 1'b0;
        chk("wr_end_oe", {31'd0, sdram_dq_oe}, 32'h0);
        tick();
        chk("rd_en", {31'd0, rd_en}, 32'h1);
        chk("rd_cmd", {28'd0, sdram_cmd}, 32'h5);
        chk("rd_addr", {19'd0, sdram_addr}, 32'h0777);
        chk("rd_ba", {30'd0, sdram_ba}, 32'h1);
        chk("rd_dq", {15'd0, sdram_dq_oe, sdram_dq_out}, 32'h0);
        rd_end = 1'b1;
        tick();
        rd_end = 1'b0;
        tick();
        chk("wr_again", {31'd0, wr_en}, 32'h1);
        wr_end = 1'b1;
        tick();
        wr_end = 1'b0;
        wr_req = 1'b0; rd_req = 1'b0;

        // Watchdog expiry on an unterminated read
        exp_q.push_back(G_RD);
        rd_req = 1'b1;
        cnt = 0; te = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            rd_req = 1'b0;
            if (rd_en) cnt++;
            if (timeout_err) te++;
        end
        chk("to_grant_len", cnt, 8);
        chk("to_err_pulses", te, 1);
        chk("to_sticky", {31'd0, err_sticky}, 32'h1);

        // rd_end on the final cycle counts as a normal end
        exp_q.push_back(G_RD);
        rd_req = 1'b1;
        cnt = 0; te = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            rd_req = 1'b0;
            rd_end = 1'b0;
            if (rd_en) cnt++;
            if (timeout_err) te++;
            if (rd_en && cnt == 8) rd_end = 1'b1;
        end
        chk("end_grant_len", cnt, 8);
        chk("end_no_err", te, 0);
        chk("end_sticky_held", {31'd0, err_sticky}, 32'h1);

        // Async reset three cycles into a write
        exp_q.push_back(G_WR);
        wr_req = 1'b1;
        tick(); tick(); tick();
        chk("pre_rst_wr", {31'd0, wr_en}, 32'h1);
        rst = 1'b1;
        #1;
        chk("rst_wr_en", {31'd0, wr_en}, 32'h0);
        chk("rst_oe", {31'd0, sdram_dq_oe}, 32'h0);
        chk("rst_mid_cmd", {28'd0, sdram_cmd}, 32'h7);
        chk("rst_sticky", {31'd0, err_sticky}, 32'h0);
        tick();
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (aref_en || wr_en || rd_en) cnt++;
        end
        chk("no_grant_before_init", cnt, 0);
        exp_q.push_back(G_WR);
        init_done = 1'b1;
        tick();
        init_done = 1'b0;
        tick();
        chk("wr_after_reinit", {31'd0, wr_en}, 32'h1);
        wr_req = 1'b0;
        wr_end = 1'b1;
        tick();
        wr_end = 1'b0;
        tick();
        chk("queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
